// File: rtl/spectrum_smoother_pkg.sv
// spectrum_smoother_pkg
//   Shared DSP definitions for the spectrum smoothing path:
//   - framing FSM state encoding (S_SYNC / S_RUN)
//   - AXI-Stream sample bundle (tdata, tuser = frame start, tlast = frame end)
//   - round_bias(): half-LSB bias for a power-of-two divide
package spectrum_smoother_pkg;

  // Native sample width of the magnitude stream; the sample struct is sized by it.
  localparam int SAMPLE_DW = 16;

  typedef enum logic [0:0] {
    S_SYNC = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [SAMPLE_DW-1:0] tdata;
    logic                 tuser;
    logic                 tlast;
  } axis_sample_t;

  // Bias added before a right shift by log2_win to round half up; zero for no shift.
  function automatic int round_bias(input int log2_win);
    if (log2_win == 0) begin
      return 0;
    end else begin
      return 32'sd1 <<< (log2_win - 1);
    end
  endfunction

endpackage

// File: rtl/spectrum_smoother_moving.sv
// moving_sum
//   History shift register plus running accumulator for a 2^LOG2_WIN boxcar.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     clear      : current sample starts a new frame (history restarts at x)
//     en         : current sample is processed (state advances)
//     x          : signed input sample, DW bits
//     sum_next   : combinational running sum including x, DW+LOG2_WIN bits
module moving_sum
  import spectrum_smoother_pkg::*;
#(
  parameter int DW       = SAMPLE_DW,
  parameter int LOG2_WIN = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [DW-1:0]         x,
  output logic signed [DW+LOG2_WIN-1:0] sum_next
);

  localparam int WIN = 1 << LOG2_WIN;
  localparam int SW  = DW + LOG2_WIN;

  logic signed [SW-1:0] sum_r;
  logic signed [DW-1:0] hist_r [WIN];
  logic signed [SW-1:0] x_ext_s;
  logic signed [SW-1:0] old_ext_s;

  assign x_ext_s   = SW'(x);
  assign old_ext_s = SW'(hist_r[WIN-1]);

  // Next running sum: a frame start treats all earlier samples as zero.
  always_comb begin
    sum_next = sum_r;
    if (clear) begin
      sum_next = x_ext_s;
    end else begin
      sum_next = sum_r + x_ext_s - old_ext_s;
    end
  end

  // Accumulator and history update on every processed sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r <= '0;
      for (int i = 0; i < WIN; i++) hist_r[i] <= '0;
    end else if (en) begin
      sum_r <= sum_next;
      if (clear) begin
        for (int i = 1; i < WIN; i++) hist_r[i] <= '0;
      end else begin
        for (int i = 1; i < WIN; i++) hist_r[i] <= hist_r[i-1];
      end
      hist_r[0] <= x;
    end
  end

endmodule

// File: rtl/spectrum_smoother.sv
// spectrum_smoother
//   Boxcar moving-average smoother for framed AXI-Stream spectrum data, with
//   framing enforcement so downstream always sees FRAME_LEN-sample frames.
//   Optional build macro: SPECTRUM_SMOOTHER_ROUND_EN (round half up instead of
//   truncating toward minus infinity).
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     ce                : clock enable; low freezes all state and deasserts tready_s
//     smooth_en         : 1 = smoothed output, 0 = raw sample (same latency)
//     tdata_s/tuser_s/tlast_s/tvalid_s/tready_s : input stream (tuser = frame start)
//     tdata_m/tuser_m/tlast_m/tvalid_m/tready_m : output stream, one register stage
//     frame_err         : one-cycle pulse alongside an output sample that broke framing
module spectrum_smoother
  import spectrum_smoother_pkg::*;
#(
  parameter int DW        = SAMPLE_DW,
  parameter int LOG2_WIN  = 2,
  parameter int FRAME_LEN = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 smooth_en,
  input  logic signed [DW-1:0] tdata_s,
  input  logic                 tuser_s,
  input  logic                 tlast_s,
  input  logic                 tvalid_s,
  output logic                 tready_s,
  output logic signed [DW-1:0] tdata_m,
  output logic                 tuser_m,
  output logic                 tlast_m,
  output logic                 tvalid_m,
  input  logic                 tready_m,
  output logic                 frame_err
);

  localparam int SW = DW + LOG2_WIN;
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

`ifdef SPECTRUM_SMOOTHER_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'(round_bias(LOG2_WIN));
`else
  localparam logic signed [SW-1:0] RND = '0;
`endif

  state_t               state_r;
  state_t               state_next_s;
  logic [CW-1:0]        cnt_r;
  axis_sample_t         out_r;
  logic                 tvalid_r;
  logic                 frame_err_r;

  logic                 acc_s;
  logic                 proc_s;
  logic                 start_s;
  logic [CW:0]          pos_s;
  logic                 last_pos_s;
  logic                 err_s;
  logic                 tlast_out_s;
  logic signed [SW-1:0] sum_next_s;
  logic signed [SW-1:0] rounded_s;
  logic signed [DW-1:0] smooth_s;
  logic signed [DW-1:0] out_data_s;

  assign tready_s = ce && (!tvalid_r || tready_m);
  assign acc_s    = tvalid_s && tready_s;
  // In S_SYNC only a frame-start sample is taken in; everything else is dropped.
  assign proc_s   = acc_s && ((state_r == S_RUN) || tuser_s);
  assign start_s  = proc_s && tuser_s;

  // 1-based position of the current sample within its frame.
  assign pos_s       = tuser_s ? (CW+1)'(1) : ({1'b0, cnt_r} + (CW+1)'(1));
  assign last_pos_s  = (pos_s == (CW+1)'(FRAME_LEN));
  assign tlast_out_s = tlast_s || last_pos_s;
  assign err_s       = (tuser_s && (state_r == S_RUN) && ({1'b0, cnt_r} != (CW+1)'(FRAME_LEN)))
                     || (tlast_s != last_pos_s);

  moving_sum #(
    .DW       (DW),
    .LOG2_WIN (LOG2_WIN)
  ) u_moving_sum (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_s),
    .en       (proc_s),
    .x        (tdata_s),
    .sum_next (sum_next_s)
  );

  assign rounded_s  = sum_next_s + RND;
  assign smooth_s   = DW'(rounded_s >>> LOG2_WIN);
  assign out_data_s = smooth_en ? smooth_s : tdata_s;

  // Framing FSM next state: any emitted frame end (real or forced) resyncs.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_SYNC: begin
        if (start_s) begin
          state_next_s = tlast_out_s ? S_SYNC : S_RUN;
        end else begin
          state_next_s = S_SYNC;
        end
      end
      S_RUN: begin
        if (proc_s && tlast_out_s) begin
          state_next_s = S_SYNC;
        end else begin
          state_next_s = S_RUN;
        end
      end
      default: state_next_s = S_SYNC;
    endcase
  end

  // FSM state and in-frame sample counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_SYNC;
      cnt_r   <= '0;
    end else if (ce) begin
      state_r <= state_next_s;
      if (proc_s) begin
        cnt_r <= start_s ? CW'(1) : cnt_r + CW'(1);
      end
    end
  end

  // Output register stage; frame_err rides with the sample it flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r       <= '0;
      tvalid_r    <= 1'b0;
      frame_err_r <= 1'b0;
    end else if (ce) begin
      if (proc_s) begin
        out_r.tdata <= out_data_s;
        out_r.tuser <= tuser_s;
        out_r.tlast <= tlast_out_s;
        tvalid_r    <= 1'b1;
        frame_err_r <= err_s;
      end else begin
        if (tready_m) begin
          tvalid_r <= 1'b0;
        end
        frame_err_r <= 1'b0;
      end
    end
  end

  assign tdata_m   = out_r.tdata;
  assign tuser_m   = out_r.tuser;
  assign tlast_m   = out_r.tlast;
  assign tvalid_m  = tvalid_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spectrum_smoother.sv
module tb_spectrum_smoother;

  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 reset, ce, smooth_en;
  logic signed [DW-1:0] tdata_s, tdata_m;
  logic                 tuser_s, tlast_s, tvalid_s, tready_s;
  logic                 tuser_m, tlast_m, tvalid_m, tready_m, frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spectrum_smoother #(.DW(DW), .LOG2_WIN(2), .FRAME_LEN(1024)) dut (
    .clk(clk), .reset(reset), .ce(ce), .smooth_en(smooth_en),
    .tdata_s(tdata_s), .tuser_s(tuser_s), .tlast_s(tlast_s),
    .tvalid_s(tvalid_s), .tready_s(tready_s),
    .tdata_m(tdata_m), .tuser_m(tuser_m), .tlast_m(tlast_m),
    .tvalid_m(tvalid_m), .tready_m(tready_m), .frame_err(frame_err)
  );

  task automatic do_reset();
    reset = 1'b1; ce = 1'b1; smooth_en = 1'b1; tready_m = 1'b1;
    tvalid_s = 1'b0; tuser_s = 1'b0; tlast_s = 1'b0; tdata_s = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One sample presented for exactly one edge; outputs checked after it.
  task automatic push(input logic signed [DW-1:0] d, input logic u, input logic l);
    tdata_s = d; tuser_s = u; tlast_s = l; tvalid_s = 1'b1;
    @(posedge clk);
    #1;
    tvalid_s = 1'b0; tuser_s = 1'b0; tlast_s = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({tvalid_m, tuser_m, tlast_m, frame_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {tvalid_m, tuser_m, tlast_m, frame_err});
    end
    n_checks++;
    if (tdata_m !== 16'sd0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", tdata_m); end
    n_checks++;
    if (tready_s !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", tready_s); end
    // reset mid-frame drops the in-flight output and forces resync
    push(16'sd8, 1'b1, 1'b0);
    do_reset();
    n_checks++;
    if (tvalid_m !== 1'b0) begin n_fail++; $display("FAIL reset_drop: tvalid_m got %b want 0", tvalid_m); end
    push(16'sd8, 1'b0, 1'b0);
    n_checks++;
    if (tvalid_m !== 1'b0) begin n_fail++; $display("FAIL reset_resync: tvalid_m got %b want 0", tvalid_m); end
  endtask

  task automatic test_averaging();
    logic signed [DW-1:0] exp_avg [4];
    logic signed [DW-1:0] exp_neg;
`ifdef SPECTRUM_SMOOTHER_ROUND_EN
    exp_avg = '{16'sd1, 16'sd1, 16'sd2, 16'sd2};
    exp_neg = 16'sd0;
`else
    exp_avg = '{16'sd0, 16'sd1, 16'sd1, 16'sd2};
    exp_neg = -16'sd1;
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(16'sd2, (i == 0), 1'b0);
      n_checks++;
      if (tvalid_m !== 1'b1 || tdata_m !== exp_avg[i] || tuser_m !== (i == 0)) begin
        n_fail++;
        $display("FAIL avg_%0d: got data %0d valid %b user %b want data %0d", i, tdata_m, tvalid_m, tuser_m, exp_avg[i]);
      end
    end
    do_reset();
    push(-16'sd1, 1'b1, 1'b0);
    n_checks++;
    if (tdata_m !== exp_neg) begin n_fail++; $display("FAIL negative: got %0d want %0d", tdata_m, exp_neg); end
  endtask

  task automatic test_frame_boundary();
    logic signed [DW-1:0] exp_d;
    do_reset();
    for (int i = 1; i <= 1024; i++) begin
      push(16'sd100, (i == 1), (i == 1024));
      exp_d = (i == 1) ? 16'sd25 : (i == 2) ? 16'sd50 : (i == 3) ? 16'sd75 : 16'sd100;
      n_checks++;
      if (tvalid_m !== 1'b1 || tdata_m !== exp_d || tuser_m !== (i == 1) ||
          tlast_m !== (i == 1024) || frame_err !== 1'b0) begin
        n_fail++;
        $display("FAIL boundary_%0d: got data %0d user %b last %b err %b want data %0d user %b last %b err 0",
                 i, tdata_m, tuser_m, tlast_m, frame_err, exp_d, (i == 1), (i == 1024));
      end
    end
    push(16'sd0, 1'b1, 1'b0);
    n_checks++;
    if (tvalid_m !== 1'b1 || tdata_m !== 16'sd0 || tuser_m !== 1'b1 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL new_frame: got data %0d valid %b user %b err %b want 0 1 1 0", tdata_m, tvalid_m, tuser_m, frame_err);
    end
  endtask

  task automatic test_forced_tlast();
    do_reset();
    for (int i = 1; i <= 1024; i++) begin
      push(16'sd8, (i == 1), 1'b0);
      n_checks++;
      if (tlast_m !== (i == 1024) || frame_err !== (i == 1024)) begin
        n_fail++;
        $display("FAIL forced_tlast_%0d: got last %b err %b want %b %b", i, tlast_m, frame_err, (i == 1024), (i == 1024));
      end
    end
    push(16'sd8, 1'b0, 1'b0);
    n_checks++;
    if (tvalid_m !== 1'b0) begin n_fail++; $display("FAIL forced_resync: tvalid_m got %b want 0", tvalid_m); end
  endtask

  task automatic test_short_frame();
    logic signed [DW-1:0] exp_d;
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      push(16'sd8, (i == 1), (i == 10));
      exp_d = (i < 4) ? DW'(2 * i) : 16'sd8;
      n_checks++;
      if (tdata_m !== exp_d || tlast_m !== (i == 10) || frame_err !== (i == 10)) begin
        n_fail++;
        $display("FAIL short_%0d: got data %0d last %b err %b want %0d %b %b", i, tdata_m, tlast_m, frame_err, exp_d, (i == 10), (i == 10));
      end
    end
    for (int i = 0; i < 3; i++) begin
      push(16'sd8, 1'b0, 1'b0);
      n_checks++;
      if (tvalid_m !== 1'b0) begin n_fail++; $display("FAIL short_drop_%0d: tvalid_m got %b want 0", i, tvalid_m); end
    end
    push(16'sd8, 1'b1, 1'b0);
    n_checks++;
    if (tvalid_m !== 1'b1 || tuser_m !== 1'b1 || tdata_m !== 16'sd2 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL short_restart: got valid %b user %b data %0d err %b want 1 1 2 0", tvalid_m, tuser_m, tdata_m, frame_err);
    end
  endtask

  task automatic test_framing_errors();
    // unexpected frame start inside a running frame
    do_reset();
    push(16'sd8, 1'b1, 1'b0);
    push(16'sd8, 1'b0, 1'b0);
    push(16'sd4, 1'b1, 1'b0);
    n_checks++;
    if (frame_err !== 1'b1 || tuser_m !== 1'b1 || tdata_m !== 16'sd1 || tlast_m !== 1'b0) begin
      n_fail++;
      $display("FAIL early_start: got err %b user %b data %0d last %b want 1 1 1 0", frame_err, tuser_m, tdata_m, tlast_m);
    end
    push(16'sd4, 1'b0, 1'b0);
    n_checks++;
    if (frame_err !== 1'b0 || tdata_m !== 16'sd2) begin
      n_fail++; $display("FAIL early_start_next: got err %b data %0d want 0 2", frame_err, tdata_m);
    end
    // frame start and end on the same sample
    do_reset();
    push(16'sd8, 1'b1, 1'b1);
    n_checks++;
    if ({tuser_m, tlast_m, frame_err} !== 3'b111 || tdata_m !== 16'sd2) begin
      n_fail++; $display("FAIL start_end: got flags %b data %0d want 111 2", {tuser_m, tlast_m, frame_err}, tdata_m);
    end
    push(16'sd8, 1'b0, 1'b0);
    n_checks++;
    if (tvalid_m !== 1'b0) begin n_fail++; $display("FAIL start_end_resync: tvalid_m got %b want 0", tvalid_m); end
  endtask

  task automatic test_passthrough();
    do_reset();
    smooth_en = 1'b0;
    push(16'sd7, 1'b1, 1'b0);
    n_checks++;
    if (tdata_m !== 16'sd7) begin n_fail++; $display("FAIL raw_0: got %0d want 7", tdata_m); end
    push(-16'sd3, 1'b0, 1'b0);
    n_checks++;
    if (tdata_m !== -16'sd3) begin n_fail++; $display("FAIL raw_1: got %0d want -3", tdata_m); end
    smooth_en = 1'b1;
    push(16'sd9, 1'b0, 1'b0);
    n_checks++;
    if (tdata_m !== 16'sd3) begin n_fail++; $display("FAIL raw_to_smooth: got %0d want 3", tdata_m); end
  endtask

  task automatic test_clock_enable();
    do_reset();
    push(16'sd8, 1'b1, 1'b0);
    ce = 1'b0; tvalid_s = 1'b1; tdata_s = 16'sd100;
    #1;
    n_checks++;
    if (tready_s !== 1'b0) begin n_fail++; $display("FAIL ce_ready: got %b want 0", tready_s); end
    @(posedge clk); #1;
    n_checks++;
    if (tvalid_m !== 1'b1 || tdata_m !== 16'sd2) begin
      n_fail++; $display("FAIL ce_hold: got valid %b data %0d want 1 2", tvalid_m, tdata_m);
    end
    ce = 1'b1; tvalid_s = 1'b0;
    push(16'sd8, 1'b0, 1'b0);
    n_checks++;
    if (tdata_m !== 16'sd4) begin n_fail++; $display("FAIL ce_resume: got %0d want 4", tdata_m); end
  endtask

  task automatic test_back_pressure();
    logic signed [DW-1:0] in_d [7];
    logic signed [DW-1:0] exp_d [7];
    int   src, snk;
    logic in_fire, out_fire;
    in_d  = '{16'sd4, 16'sd8, 16'sd12, 16'sd16, 16'sd20, 16'sd24, 16'sd28};
    exp_d = '{16'sd1, 16'sd3, 16'sd6, 16'sd10, 16'sd14, 16'sd18, 16'sd22};
    src = 0; snk = 0;
    do_reset();
    for (int cyc = 0; cyc < 40 && snk < 7; cyc++) begin
      tready_m = !(cyc >= 3 && cyc < 8);
      if (src < 7) begin
        tvalid_s = 1'b1; tdata_s = in_d[src]; tuser_s = (src == 0);
      end else begin
        tvalid_s = 1'b0; tuser_s = 1'b0;
      end
      #1;
      in_fire  = tvalid_s && tready_s;
      out_fire = tvalid_m && tready_m;
      if (tvalid_m && !tready_m) begin
        n_checks++;
        if (tready_s !== 1'b0 || tdata_m !== exp_d[snk]) begin
          n_fail++;
          $display("FAIL stall_cyc%0d: got ready %b data %0d want 0 %0d", cyc, tready_s, tdata_m, exp_d[snk]);
        end
      end
      if (out_fire) begin
        n_checks++;
        if (tdata_m !== exp_d[snk]) begin
          n_fail++; $display("FAIL bp_out_%0d: got %0d want %0d", snk, tdata_m, exp_d[snk]);
        end
        snk++;
      end
      @(posedge clk); #1;
      if (in_fire) src++;
    end
    tvalid_s = 1'b0; tuser_s = 1'b0; tready_m = 1'b1;
    n_checks++;
    if (snk !== 7) begin n_fail++; $display("FAIL bp_count: got %0d outputs want 7", snk); end
  endtask

  initial begin
    test_reset();
    test_averaging();
    test_frame_boundary();
    test_forced_tlast();
    test_short_frame();
    test_framing_errors();
    test_passthrough();
    test_clock_enable();
    test_back_pressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spectrum_smoother.md
# spectrum_smoother

Boxcar moving-average smoother for framed spectrum data. It sits directly upstream of the prominence analyser and takes the magnitude stream (AXI-Stream, `tuser` = frame start, `tlast` = frame end). It re-emits the stream smoothed over a 2^LOG2_WIN-sample window that restarts at every frame. It also enforces frame framing, so the analyser always sees well-formed FRAME_LEN-sample frames.

## Interface
- `DW`, 16: sample width, signed two's complement.
- `LOG2_WIN`, 2: window is 2^LOG2_WIN samples; legal range 0–4.
- `FRAME_LEN`, 1024: expected samples per frame.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `ce` in 1: clock enable. While low, all registers hold and `tready_s`=0.
- `smooth_en` in 1: 1 selects the smoothed output; 0 passes the raw sample through at the same latency.
- `tdata_s` in DW: input sample.
- `tuser_s` in 1: input frame start.
- `tlast_s` in 1: input frame end.
- `tvalid_s` in 1: input valid.
- `tready_s` out 1: input ready.
- `tdata_m` out DW: output sample.
- `tuser_m` out 1: output frame start.
- `tlast_m` out 1: output frame end.
- `tvalid_m` out 1: output valid.
- `tready_m` in 1: output ready.
- `frame_err` out 1: one-cycle pulse on a framing violation.

## Operation
- Accept condition: `acc` = `ce && tvalid_s && tready_s`.
- `tready_s` = `ce && (!tvalid_m || tready_m)`. This is combinational, with a single output register stage and no skid buffer.
- FSM has two states:
  - S_SYNC (reset state): `tready_s` as above; accepted samples are discarded unless `tuser_s`=1. On an accepted `tuser_s`=1 sample, process it as the frame's first sample and go to S_RUN.
  - S_RUN: every accepted sample is processed and emitted.
- Sample counter `cnt` is $clog2(FRAME_LEN) bits. It is loaded to 1 on frame start and incremented on each processed sample.
- History is WIN registers `hist[0..WIN-1]`. Accumulator `sum` is DW+LOG2_WIN bits, signed.
- On a frame-start sample x (`tuser_s`=1): `hist` is cleared, `hist[0]`=x, `sum`=x. Samples before the frame start count as 0.
- On any other sample: `sum` = `sum` + x − `hist[WIN-1]`, then `hist` shifts and `hist[0]`=x.
- Output `tdata_m` = `sum_next` >>> LOG2_WIN (arithmetic shift, lower DW bits; no saturation is needed).
- When `smooth_en`=0, `tdata_m` = x. History still updates, so toggling `smooth_en` mid-frame is glitch-free.
- `tuser_m` and `tlast_m` follow the input flags, with the overrides below.

Boundary rules:
- **`tuser_s`=1 in S_RUN with `cnt`≠FRAME_LEN:** `frame_err` pulses. The sample is treated as a new frame start, and the previous frame is left without `tlast`.
- **`tlast_s`=1 with `cnt+1`≠FRAME_LEN:** the sample passes with `tlast_m`=1, `frame_err` pulses, and the FSM goes to S_SYNC.
- **`cnt+1`=FRAME_LEN and `tlast_s`=0:** the block forces `tlast_m`=1, pulses `frame_err`, and goes to S_SYNC.
- **`cnt+1`=FRAME_LEN and `tlast_s`=1:** normal frame end; the FSM goes to S_SYNC.
- **Frame start and end on the same sample:** the sample is emitted with `tuser_m`=`tlast_m`=1. `frame_err` pulses unless FRAME_LEN=1.

## Timing
- Latency is one cycle: a sample accepted at edge n is presented on `tdata_m`/`tvalid_m` after edge n.
- `tvalid_m` sets on accept and clears on `tready_m` without a new accept. Output holds stable while `tvalid_m && !tready_m`.
- Full throughput of one sample per clock when `tready_m`=1.
- `frame_err` is registered and asserts in the same cycle the offending sample appears on the output.
- Reset values: `tvalid_m`=0, `tdata_m`=0, `tuser_m`=0, `tlast_m`=0, `frame_err`=0, FSM=S_SYNC, `sum`=0, `hist`=0, `cnt`=0.
- Reset mid-frame drops the in-flight output. The block then resyncs on the next `tuser_s`.

## Configuration
- `SPECTRUM_SMOOTHER_ROUND_EN` defined: add 2^(LOG2_WIN−1) to `sum_next` before the shift (round half up). When LOG2_WIN=0 the adder is zero.
- Macro undefined: truncate toward −∞ (plain arithmetic shift).

## Structure
- The shared DSP package holds:
  - FSM state constants S_SYNC and S_RUN.
  - An AXI-Stream sample struct holding tdata, tuser and tlast.
- One sub-module, `moving_sum`, holds the history shift register and the accumulator. It has ports clear, en and x, and outputs `sum_next`.
- The framing FSM and the output register stay in the top module.

## Test plan
- **Truncation:** LOG2_WIN=2, macro undefined, frame start then samples 2,2,2,2 → `tdata_m` 0,1,1,2.
- **Rounding:** same stimulus with `SPECTRUM_SMOOTHER_ROUND_EN` defined → `tdata_m` 1,1,2,2.
- **Negative input:** frame start with −1 → 0 when rounding, −1 when truncating.
- **Frame boundary:** 1024-sample frame of 100s followed by a `tuser` sample of 0 → first output of the new frame is 0. `tlast_m` is on sample 1024 only, and `frame_err` stays 0.
- **Short frame:** `tlast_s` on sample 10 → `tlast_m` on output 10 and a `frame_err` pulse. Following samples are dropped until `tuser_s`.
- **Back-pressure:** hold `tready_m`=0 for 5 cycles mid-frame → `tready_s`=0, output held, no samples lost; the output sequence matches the unstalled reference.
